// File: rtl/cpu_sram_slave.sv
// Dual-port (instruction + data) SRAM slave with byte-lane writes, 1-cycle read latency and an out-of-window error latch.
// Optional macro SRAM_XPORT_FWD_EN: a read on one port returns the other port's same-cycle write to the same word.
module cpu_sram_slave #(
    parameter int          ADDR_W = 14,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,

    output logic        err,
    output logic [31:0] err_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    // Port contract: en is a one-cycle strobe with no back-pressure; every accepted
    // access (read or write) returns rdata on the following cycle, and rdata holds
    // its value for as long as en stays low.

    logic [31:0] r_mem [DEPTH];

    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_err;
    logic [31:0] r_err_addr;

    logic [ADDR_W-1:0] w_inst_idx;
    logic [ADDR_W-1:0] w_data_idx;
    logic              w_inst_hit;
    logic              w_data_hit;
    logic              w_inst_acc;
    logic              w_data_acc;
    logic              w_inst_wr;
    logic              w_data_wr;
    logic              w_inst_bad;
    logic              w_data_bad;
    logic              w_same_word;
    logic [3:0]        w_inst_mask_on_inst;
    logic [3:0]        w_data_mask_on_inst;
    logic [3:0]        w_inst_mask_on_data;
    logic [3:0]        w_data_mask_on_data;
    logic [31:0]       w_inst_old;
    logic [31:0]       w_data_old;
    logic [31:0]       w_inst_new;
    logic [31:0]       w_data_new;
    logic [31:0]       w_inst_rword;
    logic [31:0]       w_data_rword;
    logic              w_unused_addr_lsbs;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lane_mask
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign w_inst_idx = inst_sram_addr[ADDR_W+1:2];
    assign w_data_idx = data_sram_addr[ADDR_W+1:2];
    assign w_inst_hit = (inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign w_data_hit = (data_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);

    // Gating with resetn keeps accesses presented during reset from reaching the array.
    assign w_inst_acc = resetn & inst_sram_en;
    assign w_data_acc = resetn & data_sram_en;
    assign w_inst_wr  = w_inst_acc & w_inst_hit & (|inst_sram_wen);
    assign w_data_wr  = w_data_acc & w_data_hit & (|data_sram_wen);
    assign w_inst_bad = w_inst_acc & ~w_inst_hit;
    assign w_data_bad = w_data_acc & ~w_data_hit;

    assign w_same_word = (w_inst_idx == w_data_idx);

    always_comb begin
        w_inst_mask_on_inst = w_inst_wr ? inst_sram_wen : 4'b0000;
        w_data_mask_on_data = w_data_wr ? data_sram_wen : 4'b0000;
        w_data_mask_on_inst = (w_data_wr && w_same_word) ? data_sram_wen : 4'b0000;
        w_inst_mask_on_data = (w_inst_wr && w_same_word) ? inst_sram_wen : 4'b0000;
    end

    assign w_inst_old = r_mem[w_inst_idx];
    assign w_data_old = r_mem[w_data_idx];

    // Inst lanes first, data lanes on top: data wins where both ports enable a lane.
    assign w_inst_new = lane_merge(lane_merge(w_inst_old, inst_sram_wdata, w_inst_mask_on_inst),
                                   data_sram_wdata, w_data_mask_on_inst);
    assign w_data_new = lane_merge(lane_merge(w_data_old, inst_sram_wdata, w_inst_mask_on_data),
                                   data_sram_wdata, w_data_mask_on_data);

`ifdef SRAM_XPORT_FWD_EN
    assign w_inst_rword = w_inst_new;
    assign w_data_rword = w_data_new;
`else
    // A pure read sees the stored word even if the other port writes it this cycle.
    assign w_inst_rword = w_inst_wr ? w_inst_new : w_inst_old;
    assign w_data_rword = w_data_wr ? w_data_new : w_data_old;
`endif

    // Both writes to one word carry the identical fully merged value.
    always_ff @(posedge clk) begin
        if (w_inst_wr) begin
            r_mem[w_inst_idx] <= w_inst_new;
        end
        if (w_data_wr) begin
            r_mem[w_data_idx] <= w_data_new;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_rdata <= 32'h0;
        end else if (inst_sram_en) begin
            r_inst_rdata <= w_inst_hit ? w_inst_rword : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_rdata <= 32'h0;
        end else if (data_sram_en) begin
            r_data_rdata <= w_data_hit ? w_data_rword : 32'h0;
        end
    end

    // err is sticky; err_addr records only the first fault, data port taking priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'h0;
        end else begin
            if (w_inst_bad || w_data_bad) begin
                r_err <= 1'b1;
            end
            if (!r_err) begin
                if (w_data_bad) begin
                    r_err_addr <= data_sram_addr;
                end else if (w_inst_bad) begin
                    r_err_addr <= inst_sram_addr;
                end
            end
        end
    end

    assign w_unused_addr_lsbs = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

    assign inst_sram_rdata = r_inst_rdata;
    assign data_sram_rdata = r_data_rdata;
    assign err             = r_err;
    assign err_addr        = r_err_addr;

endmodule

// File: tb/tb_cpu_sram_slave.sv
// Directed self-checking bench for cpu_sram_slave (default ADDR_W=14, BASE=0).
module tb_cpu_sram_slave;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        err;
    logic [31:0] err_addr;

    int n_checks;
    int n_failures;

    logic [31:0] exp_xport;

    cpu_sram_slave dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .err             (err),
        .err_addr        (err_addr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inst(input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wdata);
        inst_sram_en    = en;
        inst_sram_wen   = wen;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
    endtask

    task automatic drive_data(input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    task automatic idle();
        drive_inst(1'b0, 4'h0, 32'h0, 32'h0);
        drive_data(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_failures = 0;
        resetn     = 1'b0;
        idle();
        repeat (2) tick();
        check("reset_inst_rdata", inst_sram_rdata, 32'h0);
        check("reset_data_rdata", data_sram_rdata, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_err_addr", err_addr, 32'h0);
        resetn = 1'b1;

        // Full write, write-first readback, cross-port read next cycle
        drive_data(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
        tick();
        check("wr_first_0x10", data_sram_rdata, 32'hDEADBEEF);
        drive_data(1'b0, 4'h0, 32'h0, 32'h0);
        drive_inst(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        check("inst_rd_0x10", inst_sram_rdata, 32'hDEADBEEF);
        check("data_hold_en0", data_sram_rdata, 32'hDEADBEEF);
        idle();

        // Byte-lane partial write
        drive_data(1'b1, 4'b1111, 32'h20, 32'h11223344);
        tick();
        drive_data(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        tick();
        check("partial_wr_first", data_sram_rdata, 32'h11BB33DD);
        drive_data(1'b1, 4'b0000, 32'h22, 32'h0);
        tick();
        check("partial_rd_0x20", data_sram_rdata, 32'h11BB33DD);

        // Cross-port same-cycle write/read
        drive_data(1'b1, 4'b1111, 32'h30, 32'h00000000);
        tick();
        drive_data(1'b1, 4'b1111, 32'h30, 32'h12345678);
        drive_inst(1'b1, 4'b0000, 32'h30, 32'h0);
        tick();
`ifdef SRAM_XPORT_FWD_EN
        exp_xport = 32'h12345678;
`else
        exp_xport = 32'h00000000;
`endif
        check("xport_inst_rd", inst_sram_rdata, exp_xport);
        check("xport_data_wr", data_sram_rdata, 32'h12345678);
        drive_data(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("xport_inst_rd2", inst_sram_rdata, 32'h12345678);

        // Both ports write the same word
        drive_data(1'b1, 4'b0011, 32'h40, 32'h0000AAAA);
        drive_inst(1'b1, 4'b1111, 32'h40, 32'hBBBBBBBB);
        tick();
        check("dual_wr_data_rd", data_sram_rdata, 32'hBBBBAAAA);
        drive_data(1'b0, 4'h0, 32'h0, 32'h0);
        drive_inst(1'b1, 4'b0000, 32'h40, 32'h0);
        tick();
        check("dual_wr_rd_0x40", inst_sram_rdata, 32'hBBBBAAAA);

        // Independent writes to different words, plus top word of the window
        drive_inst(1'b1, 4'b1111, 32'h44, 32'h01020304);
        drive_data(1'b1, 4'b1111, 32'hFFFC, 32'hCAFEF00D);
        tick();
        drive_inst(1'b1, 4'b0000, 32'hFFFC, 32'h0);
        drive_data(1'b1, 4'b0000, 32'h44, 32'h0);
        tick();
        check("top_word_rd", inst_sram_rdata, 32'hCAFEF00D);
        check("diff_word_rd", data_sram_rdata, 32'h01020304);
        check("no_err_yet", {31'b0, err}, 32'h0);
        idle();

        // Out-of-window faults
        drive_data(1'b1, 4'b0000, 32'h0001_0000, 32'h0);
        tick();
        check("oow_rdata", data_sram_rdata, 32'h0);
        check("oow_err", {31'b0, err}, 32'h1);
        check("oow_err_addr", err_addr, 32'h0001_0000);
        drive_data(1'b1, 4'b1111, 32'h0001_0010, 32'h0);
        drive_inst(1'b1, 4'b0000, 32'h0002_0000, 32'h0);
        tick();
        check("oow2_err_addr", err_addr, 32'h0001_0000);
        check("oow2_inst_rdata", inst_sram_rdata, 32'h0);
        drive_data(1'b0, 4'h0, 32'h0, 32'h0);
        drive_inst(1'b1, 4'b0000, 32'h10, 32'h0);
        tick();
        check("oow_wr_dropped", inst_sram_rdata, 32'hDEADBEEF);
        check("err_sticky", {31'b0, err}, 32'h1);
        idle();

        // Asynchronous reset mid-read; accesses during reset are ignored
        drive_data(1'b1, 4'b0000, 32'h10, 32'h0);
        tick();
        check("pre_reset_rd", data_sram_rdata, 32'hDEADBEEF);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_rdata", data_sram_rdata, 32'h0);
        check("async_rst_err", {31'b0, err}, 32'h0);
        check("async_rst_err_addr", err_addr, 32'h0);
        drive_data(1'b1, 4'b1111, 32'h10, 32'h0);
        drive_inst(1'b1, 4'b1111, 32'h0003_0000, 32'h0);
        repeat (2) tick();
        check("rst_hold_rdata", data_sram_rdata, 32'h0);
        check("rst_hold_err", {31'b0, err}, 32'h0);
        idle();
        resetn = 1'b1;
        drive_data(1'b1, 4'b0000, 32'h10, 32'h0);
        tick();
        check("mem_kept_0x10", data_sram_rdata, 32'hDEADBEEF);
        check("post_rst_err", {31'b0, err}, 32'h0);

        // Simultaneous faults on both ports: data address recorded
        drive_inst(1'b1, 4'b0000, 32'h0003_0000, 32'h0);
        drive_data(1'b1, 4'b0000, 32'h0004_0000, 32'h0);
        tick();
        check("dual_fault_err", {31'b0, err}, 32'h1);
        check("dual_fault_addr", err_addr, 32'h0004_0000);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/cpu_sram_slave.md
CPU_SRAM_SLAVE -- requirements
Module: cpu_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning word-address bits (2^ADDR_W words, 64 KB at default).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning the base byte address of the window; BASE[ADDR_W+1:0] is ignored.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_sram_en  input  1  instruction-port access strobe.
REQ-006 SHALL have port inst_sram_wen  input  4  instruction-port byte write enables.
REQ-007 SHALL have ports inst_sram_addr and inst_sram_wdata, each input, 32 bits: byte address and write data.
REQ-008 SHALL have port inst_sram_rdata  output  32  instruction-port read data.
REQ-009 SHALL have data-port ports data_sram_en (1), data_sram_wen (4), data_sram_addr (32), data_sram_wdata (32) as inputs and data_sram_rdata (32) as output, with the same meanings as the instruction port.
REQ-010 SHALL have port err  output  1  sticky flag for any out-of-window access.
REQ-011 SHALL have port err_addr  output  32  byte address of the first out-of-window access.

Function
REQ-012 Each port SHALL use a word index of addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-013 An access SHALL be in-window when addr[31:ADDR_W+2] == BASE[31:ADDR_W+2].
REQ-014 When en=1 and wen!=0 on an in-window access, at the clock edge: lane i (bits 8i+7:8i) written from wdata only where wen[i]=1; other lanes unchanged.
REQ-015 Read latency SHALL be exactly 1 cycle: rdata valid on the cycle after en=1, for both reads and writes.
REQ-016 Same-port write SHALL be write-first: next-cycle rdata = merged new word.
REQ-017 When en=0, rdata SHALL hold its previous value.
REQ-018 Both ports writing the same word in one cycle: data-port lanes win where both lanes are enabled; inst-port lanes are applied elsewhere.
REQ-019 Out-of-window access: next-cycle rdata = 32'h0; writes dropped; err set on next edge.
REQ-020 err_addr SHALL capture the address only when err is 0.
REQ-020a If both ports fault in the same cycle, err_addr SHALL take the data-port address.
REQ-021 err SHALL stay set until reset.
REQ-022 Memory array contents SHALL be unaffected by reset; no initialisation.

Reset
REQ-023 resetn=0 SHALL asynchronously force inst_sram_rdata=0, data_sram_rdata=0, err=0, err_addr=0.
REQ-024 An access presented while resetn=0 SHALL NOT modify memory, rdata or err.
REQ-025 The first access accepted SHALL be at the first rising edge with resetn=1.

Configuration
REQ-026 Macro SRAM_XPORT_FWD_EN SHALL control cross-port forwarding.
REQ-027 With SRAM_XPORT_FWD_EN defined, a read on one port and a write on the other port to the same word in the same cycle SHALL return the merged new word (per REQ-018 lane rules).
REQ-028 Without SRAM_XPORT_FWD_EN, that read SHALL return the pre-write word.

Verification
REQ-029 Data write addr 0x10, wen=4'b1111, wdata=0xDEADBEEF; next cycle inst read 0x10 -> inst_sram_rdata=0xDEADBEEF one cycle later.
REQ-030 Data write 0x20 full 0x11223344, then wen=4'b0101 wdata=0xAABBCCDD, then read -> 0x11BB33DD.
REQ-031 Same cycle: data write 0x30 = 0x12345678 and inst read 0x30 (old 0x0) -> 0x12345678 with SRAM_XPORT_FWD_EN, 0x00000000 without.
REQ-032 Data read of 0x0001_0000 (ADDR_W=14, BASE=0) -> rdata=0, err=1, err_addr=0x00010000; a later fault at 0x0002_0000 leaves err_addr unchanged.
REQ-033 Both ports write 0x40 same cycle, data wen=4'b0011 0x0000AAAA, inst wen=4'b1111 0xBBBBBBBB -> read 0xBBBBAAAA.
REQ-034 Assert resetn=0 mid-read with rdata=0xDEADBEEF -> rdata=0 and err=0 immediately; memory at 0x10 still 0xDEADBEEF after release.
